// File: rtl/nn_pkg.sv
// nn_pkg: shared state encoding, width helpers and saturation for the neuron sequencer
package nn_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, MAC, WRITE, DONE} state_t;

  // Data width: integer plus fraction bits
  function automatic int dw_f(int qm, int qn);
    return qm + qn;
  endfunction

  // Full product width of one data by one weight
  function automatic int pw_f(int qm, int qn, int wm, int wn);
    return qm + qn + wm + wn;
  endfunction

  // Accumulator width: N products plus bias can never overflow it
  function automatic int aw_f(int qm, int qn, int wm, int wn, int n);
    return pw_f(qm, qn, wm, wn) + $clog2(n) + 1;
  endfunction

  // Clamp a sign-extended value into a w-bit signed range
  function automatic logic signed [63:0] sat_trunc(logic signed [63:0] v, int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return v > hi ? hi : v < lo ? lo : v;
  endfunction

endpackage

// File: rtl/neuron_sequencer_if.sv
// neuron_sequencer_if: memory-side bus between the sequencer (master) and the layer/neuron memory (slave)
interface neuron_sequencer_if #(
  parameter int M  = 3,
  parameter int N  = 2,
  parameter int QM = 3,
  parameter int QN = 5,
  parameter int WM = 3,
  parameter int WN = 5
);
  import nn_pkg::*;

  localparam int DW  = dw_f(QM, QN);
  localparam int WW  = WM + WN;
  localparam int LAW = M > 2 ? $clog2(M - 1) : 1;
  localparam int NAW = $clog2(N);

  logic                 read_en;
  logic                 write_en;
  logic                 swap;
  logic [LAW-1:0]       layer_addr;
  logic [NAW-1:0]       neuron_addr;
  logic signed [DW-1:0] inputs [N];
  logic signed [WW-1:0] weights [N];
  logic signed [DW-1:0] bias;
  logic signed [DW-1:0] result;

  modport master (
    output read_en, layer_addr, neuron_addr, write_en, result, swap,
    input  inputs, weights, bias
  );

  modport slave (
    input  read_en, layer_addr, neuron_addr, write_en, result, swap,
    output inputs, weights, bias
  );

endinterface

// File: rtl/nn_mac_acc.sv
// nn_mac_acc: signed multiply-accumulate register with bias preload and shifted, activated, saturated readout
// Build option: NN_RELU_EN clamps negative sums to zero before saturation.
module nn_mac_acc
  import nn_pkg::*;
#(
  parameter int DW = 8,
  parameter int WW = 8,
  parameter int PW = 16,
  parameter int AW = 18,
  parameter int WN = 5
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 clr,
  input  logic                 en,
  input  logic signed [DW-1:0] bias,
  input  logic signed [DW-1:0] x,
  input  logic signed [WW-1:0] w,
  output logic signed [DW-1:0] result
);

  logic signed [AW-1:0] acc_q;
  logic signed [AW-1:0] acc_d;
  logic signed [AW-1:0] shifted;
  logic signed [AW-1:0] act;
  logic signed [PW-1:0] prod;

  // Bias preload aligned to the product's fraction point, else accumulate one product
  always_comb begin
    prod    = PW'(x) * PW'(w);
    acc_d   = clr ? (AW'(bias) <<< WN) : en ? acc_q + AW'(prod) : acc_q;
    shifted = acc_q >>> WN;
`ifdef NN_RELU_EN
    act     = shifted[AW-1] ? '0 : shifted;
`else
    act     = shifted;
`endif
    result  = DW'(sat_trunc(64'(act), DW));
  end

  // Accumulator register
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) acc_q <= '0;
    else       acc_q <= acc_d;

endmodule

// File: rtl/neuron_sequencer.sv
// neuron_sequencer: walks M-1 layers x N neurons, loading operands, running a serial MAC and writing results back
// Build option: NN_RELU_EN applies ReLU to each neuron result before saturation.
module neuron_sequencer
  import nn_pkg::*;
#(
  parameter int M  = 3,
  parameter int N  = 2,
  parameter int QM = 3,
  parameter int QN = 5,
  parameter int WM = 3,
  parameter int WN = 5
) (
  input  logic clk,
  input  logic nrst,
  input  logic start,
  output logic busy,
  output logic done,
  neuron_sequencer_if.master bus
);

  localparam int DW  = dw_f(QM, QN);
  localparam int WW  = WM + WN;
  localparam int PW  = pw_f(QM, QN, WM, WN);
  localparam int AW  = aw_f(QM, QN, WM, WN, N);
  localparam int LAW = M > 2 ? $clog2(M - 1) : 1;
  localparam int NAW = $clog2(N);

  state_t               state_q, state_d;
  logic [LAW-1:0]       layer_q, layer_d;
  logic [NAW-1:0]       neuron_q, neuron_d;
  logic [NAW-1:0]       k_q, k_d;
  logic signed [DW-1:0] x_q [N];
  logic signed [DW-1:0] x_d [N];
  logic signed [WW-1:0] w_q [N];
  logic signed [WW-1:0] w_d [N];
  logic                 last_neuron;
  logic                 last_layer;
  logic                 clr;
  logic                 en;

  // Next-state, address stepping and operand capture
  always_comb begin
    state_d     = state_q;
    layer_d     = layer_q;
    neuron_d    = neuron_q;
    k_d         = k_q;
    x_d         = x_q;
    w_d         = w_q;
    clr         = 1'b0;
    en          = 1'b0;
    last_neuron = neuron_q == NAW'(N - 1);
    last_layer  = layer_q == LAW'(M - 2);
    unique case (state_q)
      IDLE: if (start) begin
        state_d  = LOAD;
        layer_d  = '0;
        neuron_d = '0;
      end
      LOAD: begin
        x_d     = bus.inputs;
        w_d     = bus.weights;
        clr     = 1'b1;
        k_d     = '0;
        state_d = MAC;
      end
      MAC: begin
        en      = 1'b1;
        k_d     = k_q + 1'b1;
        state_d = k_q == NAW'(N - 1) ? WRITE : MAC;
      end
      WRITE: if (!last_neuron) begin
        neuron_d = neuron_q + 1'b1;
        state_d  = LOAD;
      end else if (!last_layer) begin
        layer_d  = layer_q + 1'b1;
        neuron_d = '0;
        state_d  = LOAD;
      end else begin
        layer_d  = '0;
        neuron_d = '0;
        state_d  = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, address, counter and operand registers
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      state_q  <= IDLE;
      layer_q  <= '0;
      neuron_q <= '0;
      k_q      <= '0;
      x_q      <= '{default: '0};
      w_q      <= '{default: '0};
    end else begin
      state_q  <= state_d;
      layer_q  <= layer_d;
      neuron_q <= neuron_d;
      k_q      <= k_d;
      x_q      <= x_d;
      w_q      <= w_d;
    end

  // Outputs decode from state and address registers only
  always_comb begin
    busy            = state_q != IDLE;
    done            = state_q == DONE;
    bus.read_en     = state_q == LOAD;
    bus.write_en    = state_q == WRITE;
    bus.swap        = state_q == WRITE && last_neuron && !last_layer;
    bus.layer_addr  = layer_q;
    bus.neuron_addr = neuron_q;
  end

  nn_mac_acc #(
    .DW(DW),
    .WW(WW),
    .PW(PW),
    .AW(AW),
    .WN(WN)
  ) u_mac (
    .clk   (clk),
    .nrst  (nrst),
    .clr   (clr),
    .en    (en),
    .bias  (bus.bias),
    .x     (x_q[k_q]),
    .w     (w_q[k_q]),
    .result(bus.result)
  );

endmodule

// File: tb/tb_neuron_sequencer.sv
// tb_neuron_sequencer: directed and randomized checks of the neuron sequencer against a network-level model
module tb_neuron_sequencer;
  localparam int M = 3, N = 2, QM = 3, QN = 5, WM = 3, WN = 5;
  localparam int DW = QM + QN, WW = WM + WN, L = M - 1;
  localparam int RUN = L * N * (N + 2) + 1;
  localparam int HI = (1 << (DW - 1)) - 1, LO = -(1 << (DW - 1));
`ifdef NN_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic clk = 1'b0, nrst = 1'b0, start = 1'b0;
  logic busy, done;

  neuron_sequencer_if #(.M(M), .N(N), .QM(QM), .QN(QN), .WM(WM), .WN(WN)) bus ();
  neuron_sequencer #(.M(M), .N(N), .QM(QM), .QN(QN), .WM(WM), .WN(WN)) dut (
    .clk(clk), .nrst(nrst), .start(start), .busy(busy), .done(done), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int x0 [N];
  int wt [L][N][N];
  int bs [L][N];
  int mem [2][N];
  int sel;
  int exp_q [$];
  int got_q [$];
  int got_a [$];
  int done_cyc, swaps, swap_idx, reads, busy_gap, swap_alone;

  function automatic int rnd(int lo, int hi);
    return lo + int'($urandom_range(hi - lo));
  endfunction

  // Network-level reference: real-valued MAC in integer units, floor, optional ReLU, clamp
  task automatic build_model();
    int x [N];
    int y [N];
    exp_q = {};
    x = x0;
    for (int l = 0; l < L; l++) begin
      for (int n = 0; n < N; n++) begin
        int acc;
        acc = bs[l][n] * (1 << WN);
        for (int i = 0; i < N; i++) acc += x[i] * wt[l][n][i];
        acc = acc >>> WN;
        if (RELU && acc < 0) acc = 0;
        acc = acc > HI ? HI : acc < LO ? LO : acc;
        y[n] = acc;
        exp_q.push_back(acc);
      end
      x = y;
    end
  endtask

  task automatic randomize_net();
    for (int i = 0; i < N; i++) x0[i] = rnd(LO, HI);
    for (int l = 0; l < L; l++)
      for (int n = 0; n < N; n++) begin
        bs[l][n] = rnd(LO, HI);
        for (int i = 0; i < N; i++) wt[l][n][i] = rnd(LO, HI);
      end
  endtask

  task automatic fill_net(input int xv, input int wv, input int bv);
    for (int i = 0; i < N; i++) x0[i] = xv;
    for (int l = 0; l < L; l++)
      for (int n = 0; n < N; n++) begin
        bs[l][n] = bv;
        for (int i = 0; i < N; i++) wt[l][n][i] = wv;
      end
  endtask

  // Ping-pong memory read port driven from the current addresses
  task automatic drive_mem();
    int la, na;
    la = int'(bus.layer_addr);
    na = int'(bus.neuron_addr);
    if (la >= L) la = 0;
    for (int i = 0; i < N; i++) begin
      bus.inputs[i]  = DW'(mem[sel][i]);
      bus.weights[i] = WW'(wt[la][na][i]);
    end
    bus.bias = DW'(bs[la][na]);
  endtask

  // One run: pulse (or hold) start, act as memory, record writes, swaps, reads and done timing
  task automatic do_run(input bit hold);
    got_q = {};
    got_a = {};
    sel = 0;
    for (int i = 0; i < N; i++) mem[0][i] = x0[i];
    done_cyc = -1; swaps = 0; swap_idx = -1; reads = 0; busy_gap = 0; swap_alone = 0;
    @(negedge clk);
    start = 1'b1;
    drive_mem();
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    for (int c = 1; c <= RUN + 8; c++) begin
      @(negedge clk);
      if (bus.read_en) reads++;
      if (!busy) busy_gap++;
      if (bus.swap && !bus.write_en) swap_alone++;
      if (bus.write_en) begin
        got_q.push_back(int'(bus.result));
        got_a.push_back(int'(bus.layer_addr) * N + int'(bus.neuron_addr));
        mem[sel ^ 1][bus.neuron_addr] = int'(bus.result);
        if (bus.swap) begin
          swaps++;
          swap_idx = got_q.size() - 1;
          sel ^= 1;
        end
      end
      if (done) begin
        done_cyc = c;
        break;
      end
      drive_mem();
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    #23;
    checks++;
    if ({busy, done, bus.read_en, bus.write_en, bus.swap} !== 5'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b expected 00000", {busy, done, bus.read_en, bus.write_en, bus.swap});
    end
    checks++;
    if (bus.layer_addr !== '0 || bus.neuron_addr !== '0) begin
      errors++;
      $display("FAIL reset_addr: got %0d/%0d expected 0/0", bus.layer_addr, bus.neuron_addr);
    end
    checks++;
    if (bus.result !== '0) begin
      errors++;
      $display("FAIL reset_result: got %0d expected 0", bus.result);
    end
    @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic test_saturation();
    fill_net(32, 32, 0);
    build_model();
    do_run(1'b0);
    checks++;
    if (got_q.size() !== L * N) begin
      errors++;
      $display("FAIL sat_writes: got %0d expected %0d", got_q.size(), L * N);
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_a[i] !== i) begin
        errors++;
        $display("FAIL sat_result[%0d]: got %0d@%0d expected %0d@%0d", i, got_q[i], got_a[i], exp_q[i], i);
      end
    end
    checks++;
    if (got_q.size() == L * N && got_q[L * N - 1] !== 127) begin
      errors++;
      $display("FAIL sat_last: got %0d expected 127", got_q[L * N - 1]);
    end
    checks++;
    if (done_cyc !== RUN) begin
      errors++;
      $display("FAIL sat_done_cycle: got %0d expected %0d", done_cyc, RUN);
    end
    checks++;
    if (swaps !== M - 2 || swap_idx !== N - 1 || swap_alone !== 0) begin
      errors++;
      $display("FAIL sat_swap: got %0d at write %0d (lone %0d) expected %0d at write %0d", swaps, swap_idx, swap_alone, M - 2, N - 1);
    end
    checks++;
    if (reads !== L * N || busy_gap !== 0) begin
      errors++;
      $display("FAIL sat_reads: got %0d reads, %0d idle expected %0d reads, 0 idle", reads, busy_gap, L * N);
    end
  endtask

  task automatic test_negative();
    fill_net(32, -32, 0);
    build_model();
    do_run(1'b0);
    checks++;
    if (got_q.size() < 1 || got_q[0] !== (RELU ? 0 : -64)) begin
      errors++;
      $display("FAIL neg_first: got %0d expected %0d", got_q.size() < 1 ? 999 : got_q[0], RELU ? 0 : -64);
    end
    checks++;
    if (got_q != exp_q) begin
      errors++;
      $display("FAIL neg_results: got %p expected %p", got_q, exp_q);
    end
  endtask

  task automatic test_truncation();
    randomize_net();
    x0[0] = 1;
    x0[1] = 0;
    for (int n = 0; n < N; n++) begin
      bs[0][n] = -1;
      wt[0][n][0] = 1;
      wt[0][n][1] = 0;
    end
    build_model();
    do_run(1'b0);
    checks++;
    if (got_q.size() < 1 || got_q[0] !== (RELU ? 0 : -1)) begin
      errors++;
      $display("FAIL trunc_first: got %0d expected %0d", got_q.size() < 1 ? 999 : got_q[0], RELU ? 0 : -1);
    end
    checks++;
    if (got_q != exp_q) begin
      errors++;
      $display("FAIL trunc_results: got %p expected %p", got_q, exp_q);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      randomize_net();
      build_model();
      do_run(1'b0);
      checks++;
      if (got_q != exp_q) begin
        errors++;
        $display("FAIL rand%0d_results: got %p expected %p", r, got_q, exp_q);
      end
      checks++;
      if (done_cyc !== RUN || swaps !== M - 2 || reads !== L * N) begin
        errors++;
        $display("FAIL rand%0d_timing: got done %0d swaps %0d reads %0d expected %0d %0d %0d", r, done_cyc, swaps, reads, RUN, M - 2, L * N);
      end
    end
  endtask

  task automatic test_abort();
    int bad;
    randomize_net();
    sel = 0;
    for (int i = 0; i < N; i++) mem[0][i] = x0[i];
    @(negedge clk);
    start = 1'b1;
    drive_mem();
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c <= 2 * (N + 2) + 3; c++) begin
      @(negedge clk);
      if (bus.write_en) mem[sel ^ 1][bus.neuron_addr] = int'(bus.result);
      if (bus.swap) sel ^= 1;
      drive_mem();
    end
    checks++;
    if (bus.layer_addr !== 1'b1 || bus.neuron_addr !== '0 || bus.read_en || bus.write_en || !busy) begin
      errors++;
      $display("FAIL abort_position: got l%0d n%0d rd%b wr%b busy%b expected l1 n0 rd0 wr0 busy1", bus.layer_addr, bus.neuron_addr, bus.read_en, bus.write_en, busy);
    end
    nrst = 1'b0;
    #1;
    checks++;
    if ({busy, done, bus.read_en, bus.write_en, bus.swap} !== 5'b0 || bus.layer_addr !== '0 || bus.neuron_addr !== '0 || bus.result !== '0) begin
      errors++;
      $display("FAIL abort_outputs: got %b l%0d n%0d r%0d expected all zero", {busy, done, bus.read_en, bus.write_en, bus.swap}, bus.layer_addr, bus.neuron_addr, bus.result);
    end
    @(negedge clk);
    nrst = 1'b1;
    bad = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (bus.write_en || done || busy) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL abort_quiet: got %0d active cycles expected 0", bad);
    end
    randomize_net();
    build_model();
    do_run(1'b0);
    checks++;
    if (got_q != exp_q || done_cyc !== RUN) begin
      errors++;
      $display("FAIL abort_rerun: got %p done %0d expected %p done %0d", got_q, done_cyc, exp_q, RUN);
    end
  endtask

  task automatic test_back_to_back();
    int second;
    randomize_net();
    build_model();
    do_run(1'b1);
    checks++;
    if (got_q != exp_q || done_cyc !== RUN || reads !== L * N || busy_gap !== 0) begin
      errors++;
      $display("FAIL b2b_first: got %p done %0d reads %0d idle %0d expected %p done %0d reads %0d idle 0", got_q, done_cyc, reads, busy_gap, exp_q, RUN, L * N);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: got busy %b expected 0", busy);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.read_en !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_restart: got rd%b busy%b expected rd1 busy1", bus.read_en, busy);
    end
    second = -1;
    for (int c = 2; c <= RUN + 8; c++) begin
      drive_mem();
      @(negedge clk);
      if (done) begin
        second = c;
        break;
      end
    end
    checks++;
    if (second !== RUN) begin
      errors++;
      $display("FAIL b2b_second_done: got %0d expected %0d", second, RUN);
    end
  endtask

  initial begin
    test_reset();
    test_saturation();
    test_negative();
    test_truncation();
    test_random();
    test_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
